rib_timer: RTL
==============

RIB_TIMER -- requirements
Module: rib_timer

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, giving the RIB address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, giving the RIB data width; only 32 is supported.
REQ-003 The module SHALL have one clock and an asynchronous active-low reset, listed first among the ports below.
REQ-004 Port clk_i  in  1  single clock, rising edge.
REQ-005 Port rst_ni  in  1  asynchronous reset, active-low.
REQ-006 Port req_i  in  1  RIB access request from the initiator, qualified by the bus decoder.
REQ-007 Port we_i  in  1  write enable: 1 = write, 0 = read; valid only with req_i.
REQ-008 Port addr_i  in  ADDR_W  byte address; only bits [4:2] are decoded.
REQ-009 Port data_i  in  DATA_W  write data.
REQ-010 Port data_o  out  DATA_W  read data, combinational in the same cycle as the request.
REQ-011 Port int_sig_o  out  1  level interrupt request toward the core's interrupt input.

Function
REQ-012 The register map (addr_i[4:2]) SHALL be as follows:
- 0 CTRL: bit0 EN; bit1 IE; bit2 PEND (write-1-to-clear); bit3 ONESHOT; bits[31:4] read 0.
- 1 COUNT: 32-bit.
- 2 CMP: 32-bit.
- 3 PRESC: bits[15:0]; bits[31:16] read 0.
- 4–7: read 0; writes ignored.
REQ-013 Bus writes SHALL take effect on the rising clk_i edge when req_i=1 and we_i=1; zero wait states.
REQ-014 Read data SHALL be driven as follows: data_o = selected register when req_i=1 and we_i=0, otherwise 0.
REQ-015 A read SHALL have no side effects.
REQ-016 Prescaler: internal 16-bit pre_cnt SHALL behave as follows:
- increments each cycle while EN=1;
- when pre_cnt==PRESC, assert tick for that cycle and set pre_cnt to 0;
- a tick therefore occurs every PRESC+1 cycles.
REQ-017 pre_cnt SHALL be forced to 0 while EN=0 and on any write to PRESC.
REQ-018 On each tick, COUNT SHALL update as follows:
- if COUNT==CMP, set COUNT to 0 and PEND to 1, and clear EN if ONESHOT=1;
- otherwise increment COUNT by 1, modulo 2^32.
REQ-019 With EN=0, COUNT SHALL hold its value.
REQ-020 CMP=0 SHALL produce a match on every tick.
REQ-021 int_sig_o SHALL equal PEND AND IE, registered-state derived with no combinational path from bus inputs.
REQ-022 If a COUNT write coincides with a tick, the written value SHALL win, and no match is evaluated that cycle.
REQ-023 If a PEND write-1-to-clear coincides with a match, PEND SHALL end at 1 (set wins).
REQ-024 If a CTRL write coincides with a one-shot expiry, EN SHALL take the written value.
REQ-025 Writing 0 to PEND SHALL leave it unchanged.
REQ-026 A CTRL write SHALL update EN, IE and ONESHOT from the data bits.
REQ-027 A CMP write coinciding with a tick SHALL use the old CMP for that tick's comparison.

Reset
REQ-028 On rst_ni=0, asynchronously and regardless of any access in progress, the following SHALL hold:
- CTRL=0, COUNT=0, CMP=32'hFFFF_FFFF, PRESC=0, pre_cnt=0;
- int_sig_o=0, and data_o=0 unless a read is presented.
REQ-029 The first tick after reset deassertion SHALL require EN to be written to 1.

Verification
REQ-030 Reset check: assert rst_ni=0 mid-count with COUNT=5 -> COUNT reads 0, CMP reads 32'hFFFF_FFFF, int_sig_o=0 immediately, without a clock edge.
REQ-031 Periodic mode check:
- setup: PRESC=0, CMP=3, CTRL=0x3;
- required: COUNT sequence 1,2,3,0; PEND and int_sig_o rise 4 cycles after the EN write;
- repeat period of 4 cycles.
REQ-032 Prescaler one-shot check:
- setup: PRESC=2, CMP=1, CTRL=0xB;
- required: COUNT increments every 3 cycles; after the match, EN reads 0 and COUNT holds at 0;
- required: PEND=1 and int_sig_o=1.
REQ-033 Set-wins collision check: write CTRL=0x7 (W1C of PEND) in the same cycle as a match -> PEND remains 1 and int_sig_o remains 1.
REQ-034 COUNT write collision check: write COUNT=0x100 in the same cycle as a tick with COUNT==CMP -> COUNT=0x100 and PEND unchanged.
REQ-035 Decode and read check:
- read offset 0x14 -> data_o=0;
- write offset 0x18 -> no register changes;
- with req_i=0 -> data_o=0;
- read PRESC after writing 0xABCD1234 -> 0x00001234.

Source files
------------

// File: rtl/rib_timer.sv
// rib_timer: memory-mapped periodic/one-shot timer on the RIB bus.
//
// Ports:
//   clk_i      - single clock, rising edge
//   rst_ni     - asynchronous reset, active-low
//   req_i      - bus access request (already qualified by the bus decoder)
//   we_i       - 1 = write, 0 = read; only meaningful with req_i
//   addr_i     - byte address; bits [4:2] select the register
//   data_i     - write data
//   data_o     - read data, combinational in the request cycle, 0 otherwise
//   int_sig_o  - level interrupt, PEND AND IE
//
// Register map (addr_i[4:2]):
//   0 CTRL  : bit0 EN, bit1 IE, bit2 PEND (write-1-to-clear), bit3 ONESHOT
//   1 COUNT : 32-bit counter
//   2 CMP   : 32-bit compare value
//   3 PRESC : 16-bit prescaler reload in bits [15:0]
//   4-7     : read 0, writes ignored

module rib_timer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              int_sig_o
);

    localparam logic [2:0] REG_CTRL  = 3'd0;
    localparam logic [2:0] REG_COUNT = 3'd1;
    localparam logic [2:0] REG_CMP   = 3'd2;
    localparam logic [2:0] REG_PRESC = 3'd3;

    logic              en;
    logic              ie;
    logic              pend;
    logic              oneshot;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] cmp;
    logic [15:0]       presc;
    logic [15:0]       pre_cnt;

    logic [2:0] reg_sel;
    logic       wr;
    logic       ctrl_wr;
    logic       count_wr;
    logic       cmp_wr;
    logic       presc_wr;
    logic       tick;
    logic       match;

    // Only bits [4:2] take part in decoding; the rest are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[ADDR_W-1:5], addr_i[1:0]};

    assign reg_sel  = addr_i[4:2];
    assign wr       = req_i & we_i;
    assign ctrl_wr  = wr && (reg_sel == REG_CTRL);
    assign count_wr = wr && (reg_sel == REG_COUNT);
    assign cmp_wr   = wr && (reg_sel == REG_CMP);
    assign presc_wr = wr && (reg_sel == REG_PRESC);

    // pre_cnt is held at 0 while disabled, so tick can only fire with EN=1.
    assign tick = en && (pre_cnt == presc);

    // A COUNT write on a tick suppresses the compare entirely, so it can
    // neither set PEND nor end a one-shot run.
    assign match = tick && (count == cmp) && !count_wr;

    assign int_sig_o = pend & ie;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            pend    <= 1'b0;
            oneshot <= 1'b0;
            count   <= '0;
            cmp     <= '1;
            presc   <= '0;
            pre_cnt <= '0;
        end else begin
            if (!en || presc_wr || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end

            if (count_wr) begin
                count <= data_i;
            end else if (tick) begin
                count <= match ? '0 : count + DATA_W'(1);
            end

            // A CTRL write overrides the one-shot auto-disable.
            if (ctrl_wr) begin
                en <= data_i[0];
            end else if (match && oneshot) begin
                en <= 1'b0;
            end

            if (ctrl_wr) begin
                ie      <= data_i[1];
                oneshot <= data_i[3];
            end

            // Set beats write-1-to-clear when both happen in the same cycle.
            if (match) begin
                pend <= 1'b1;
            end else if (ctrl_wr && data_i[2]) begin
                pend <= 1'b0;
            end

            if (cmp_wr) begin
                cmp <= data_i;
            end

            if (presc_wr) begin
                presc <= data_i[15:0];
            end
        end
    end

    always_comb begin
        data_o = '0;
        if (req_i && !we_i) begin
            case (reg_sel)
                REG_CTRL:  data_o = {{(DATA_W-4){1'b0}}, oneshot, pend, ie, en};
                REG_COUNT: data_o = count;
                REG_CMP:   data_o = cmp;
                REG_PRESC: data_o = {{(DATA_W-16){1'b0}}, presc};
                default:   data_o = '0;
            endcase
        end
    end

endmodule
